// File: rtl/peripheral_dbg_soc_dii_channel.sv
// Shared DII channel definitions: flit format used on the debug ring.
package peripheral_dbg_soc_dii_channel;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/peripheral_dbg_soc_dii_packet_buffer_pkg.sv
// Local definitions for the DII store-and-forward packet buffer.
package peripheral_dbg_soc_dii_packet_buffer_pkg;

  // One stored entry: {last, data[15:0]}
  localparam int unsigned ENTRY_W = 17;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } buf_state_e;

endpackage

// File: rtl/peripheral_dbg_soc_dii_packet_buffer_if.sv
// DII flit handshake: master drives flit, slave drives ready.
interface peripheral_dbg_soc_dii_packet_buffer_if;
  import peripheral_dbg_soc_dii_channel::*;

  dii_flit flit;
  logic    ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);

endinterface

// File: rtl/peripheral_dbg_soc_dii_packet_buffer_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module peripheral_dbg_soc_dii_packet_buffer_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/peripheral_dbg_soc_dii_packet_buffer.sv
// Store-and-forward DII packet buffer: a packet is released to the ring
// only after its last flit is stored; packets larger than DEPTH are dropped.
module peripheral_dbg_soc_dii_packet_buffer
  import peripheral_dbg_soc_dii_packet_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  peripheral_dbg_soc_dii_packet_buffer_if.slave  in,
  peripheral_dbg_soc_dii_packet_buffer_if.master out,
  output logic [CNT_WIDTH-1:0]                   packet_count,
  output logic [CNT_WIDTH-1:0]                   drop_count
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);

  buf_state_e state, state_next;

  logic [PW-1:0] rd_ptr, wr_commit, wr_spec;
  logic [PW-1:0] rd_ptr_next, wr_commit_next, wr_spec_next;

  logic               full, abort;
  logic               in_ready, in_xfer;
  logic               out_valid, out_xfer, pop_last;
  logic               wr_en, commit_pkt, drop_inc;
  logic [ENTRY_W-1:0] rd_data;

  // Full/abort use registered pointers only: a pop frees space next cycle
  assign full  = (wr_spec - rd_ptr) == DEPTH_PTR;
  assign abort = full && (rd_ptr == wr_commit);

  assign in_xfer   = in.flit.valid && in_ready;
  assign out_valid = (rd_ptr != wr_commit);
  assign out_xfer  = out_valid && out.ready;
  assign pop_last  = out_xfer && rd_data[16];

  peripheral_dbg_soc_dii_packet_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_spec[AW-1:0]),
    .wr_data ({in.flit.last, in.flit.data}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // Output flit presented straight from the head of committed storage
  always_comb begin
    out.flit.valid = out_valid;
    out.flit.last  = rd_data[16];
    out.flit.data  = rd_data[15:0];
    in.ready       = in_ready;
  end

  // Next-state, write-pointer and handshake decode
  always_comb begin
    state_next     = state;
    wr_spec_next   = wr_spec;
    wr_commit_next = wr_commit;
    in_ready       = 1'b1;
    wr_en          = 1'b0;
    commit_pkt     = 1'b0;
    drop_inc       = 1'b0;
    unique case (state)
      ST_ACCEPT: begin
        // When the open packet alone fills the buffer, keep accepting so it
        // can be discarded rather than deadlocking the producer.
        in_ready = !full || abort;
        if (in_xfer) begin
          if (abort) begin
            wr_spec_next = wr_commit;
            drop_inc     = 1'b1;
            if (!in.flit.last) state_next = ST_DROP;
          end else begin
            wr_en        = 1'b1;
            wr_spec_next = wr_spec + PW'(1);
            if (in.flit.last) begin
              wr_commit_next = wr_spec + PW'(1);
              commit_pkt     = 1'b1;
            end
          end
        end
      end
      ST_DROP: begin
        if (in_xfer && in.flit.last) state_next = ST_ACCEPT;
      end
      default: state_next = ST_ACCEPT;
    endcase
  end

  assign rd_ptr_next = out_xfer ? rd_ptr + PW'(1) : rd_ptr;

  // State, pointer and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_ACCEPT;
      rd_ptr       <= '0;
      wr_commit    <= '0;
      wr_spec      <= '0;
      packet_count <= '0;
      drop_count   <= '0;
    end else begin
      state     <= state_next;
      rd_ptr    <= rd_ptr_next;
      wr_commit <= wr_commit_next;
      wr_spec   <= wr_spec_next;
      unique case ({commit_pkt, pop_last})
        2'b10:   packet_count <= packet_count + CNT_WIDTH'(1);
        2'b01:   packet_count <= packet_count - CNT_WIDTH'(1);
        default: packet_count <= packet_count;
      endcase
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_soc_dii_packet_buffer.sv
// Scoreboard bench for the DII store-and-forward packet buffer.
module tb_peripheral_dbg_soc_dii_packet_buffer;

  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] packet_count, drop_count;

  peripheral_dbg_soc_dii_packet_buffer_if in_if ();
  peripheral_dbg_soc_dii_packet_buffer_if out_if ();

  peripheral_dbg_soc_dii_packet_buffer #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in_if),
    .out          (out_if),
    .packet_count (packet_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int   tests  = 0;
  int   fails  = 0;
  int   pops   = 0;
  int   cycles = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk) cycles++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output flit must match the scoreboard head
  always @(negedge clk) begin
    if (rst && out_if.flit.valid && out_if.ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got data 0x%0h last %0b, expected no flit",
                 out_if.flit.data, out_if.flit.last);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_if.flit.data), 32'(mon_e.data));
        chk("out_last", 32'(out_if.flit.last), 32'(mon_e.last));
      end
    end
  end

  // Drive one flit starting at posedge+1; returns at posedge+1 after acceptance
  task automatic send_flit(input logic [15:0] d, input logic l, input bit expect_out);
    bit acc;
    acc = 1'b0;
    in_if.flit.valid = 1'b1;
    in_if.flit.last  = l;
    in_if.flit.data  = d;
    if (expect_out) exp_q.push_back('{last: l, data: d});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_if.ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles, required 1 (data 0x%0h)", d);
    end
    in_if.flit.valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [15:0] base, input bit expect_out);
    for (int i = 0; i < len; i++)
      send_flit(base + 16'(i), (i == len - 1), expect_out);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int p0, c0;

  initial begin
    in_if.flit   = '0;
    out_if.ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_if.flit.valid), 32'd0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
    chk("rst_packet_count", 32'(packet_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single 3-flit packet, sink always ready
    out_if.ready = 1'b1;
    send_flit(16'hA001, 1'b0, 1'b1);
    chk("single_hold1", 32'(out_if.flit.valid), 32'd0);
    send_flit(16'hA002, 1'b0, 1'b1);
    chk("single_hold2", 32'(out_if.flit.valid), 32'd0);
    send_flit(16'hA003, 1'b1, 1'b1);
    chk("single_latency_valid", 32'(out_if.flit.valid), 32'd1);
    chk("single_pkt_count1", 32'(packet_count), 32'd1);
    wait_drain("single_drain");
    chk("single_pkt_count0", 32'(packet_count), 32'd0);

    // Four 4-flit packets under backpressure fill the buffer exactly
    out_if.ready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(4, 16'hB000 + 16'(p * 16), 1'b1);
    chk("bp_full_in_ready", 32'(in_if.ready), 32'd0);
    chk("bp_pkt_count4", 32'(packet_count), 32'd4);
    chk("bp_out_valid", 32'(out_if.flit.valid), 32'd1);
    out_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_same_cycle", 32'(in_if.ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_ready_after_pop", 32'(in_if.ready), 32'd1);
    wait_drain("bp_drain");
    chk("bp_pkt_count0", 32'(packet_count), 32'd0);

    // Oversize 20-flit packet: 16 stored, 17th aborts, rest dropped
    for (int i = 1; i <= 20; i++) begin
      send_flit(16'hC000 + 16'(i), (i == 20), 1'b0);
      if (i == 16) begin
        chk("ovr_abort_ready", 32'(in_if.ready), 32'd1);
        chk("ovr_drop_before", 32'(drop_count), 32'd0);
      end
      if (i == 17) chk("ovr_drop_at17", 32'(drop_count), 32'd1);
    end
    chk("ovr_no_output", 32'(out_if.flit.valid), 32'd0);
    chk("ovr_drop_final", 32'(drop_count), 32'd1);
    chk("ovr_pkt_count", 32'(packet_count), 32'd0);
    send_pkt(2, 16'hD001, 1'b1);
    wait_drain("ovr_follow_drain");

    // Oversize packet whose last flit lands on the abort cycle
    for (int i = 1; i <= 17; i++) send_flit(16'hE000 + 16'(i), (i == 17), 1'b0);
    chk("ovr17_drop", 32'(drop_count), 32'd2);
    chk("ovr17_no_output", 32'(out_if.flit.valid), 32'd0);
    send_flit(16'hE100, 1'b1, 1'b1);
    wait_drain("ovr17_accept_drain");

    // Streaming 2-flit packets at full rate on both sides
    p0 = pops;
    c0 = cycles;
    for (int p = 0; p < 8; p++) send_pkt(2, 16'hF000 + 16'(p * 2), 1'b1);
    chk("stream_in_cycles", 32'(cycles - c0), 32'd16);
    chk("stream_out_pops", 32'(pops - p0), 32'd14);
    wait_drain("stream_drain");
    chk("stream_total_pops", 32'(pops - p0), 32'd16);
    chk("stream_no_drop", 32'(drop_count), 32'd2);

    // Async reset with two complete packets and a partial one stored
    out_if.ready = 1'b0;
    send_pkt(2, 16'h7001, 1'b0);
    send_pkt(2, 16'h7011, 1'b0);
    for (int i = 0; i < 3; i++) send_flit(16'h7101 + 16'(i), 1'b0, 1'b0);
    chk("arst_pre_pkts", 32'(packet_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_if.flit.valid), 32'd0);
    chk("arst_pkt_count", 32'(packet_count), 32'd0);
    chk("arst_drop_count", 32'(drop_count), 32'd0);
    chk("arst_in_ready", 32'(in_if.ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_post_idle", 32'(out_if.flit.valid), 32'd0);
    send_pkt(2, 16'h9001, 1'b1);
    wait_drain("arst_next_drain");
    chk("arst_final_drop", 32'(drop_count), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peripheral_dbg_soc_dii_packet_buffer.md
Name: peripheral_dbg_soc_dii_packet_buffer

Overview:
- Store-and-forward packet buffer placed directly upstream of one debug ring port (drives dii_in[i], observes dii_in_ready[i]).
- Accepts DII flits from a debug module and releases a packet to the ring only once its last flit is stored, so packets never stall mid-flight on the ring.
- A packet that can never fit (longer than DEPTH) is discarded whole and counted.

Parameters:
- DEPTH, 16, flit storage entries; power of two, >= 2.
- CNT_WIDTH, 16, width of drop/packet counters.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- in  input  dii_flit  flit from producer (valid, last, data[15:0]).
- in_ready  output  1  buffer accepts in this cycle.
- out  output  dii_flit  flit toward ring port dii_in.
- out_ready  input  1  ring port dii_in_ready.
- packet_count  output  CNT_WIDTH  complete packets currently stored.
- drop_count  output  CNT_WIDTH  packets discarded since reset; saturating.

Behaviour:
- Storage: DEPTH x 17 bits (data, last). Pointers rd_ptr, wr_commit, wr_spec, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH. Full = (wr_spec - rd_ptr) == DEPTH.
- Reset (rst=0, async): pointers 0, state ACCEPT, packet_count 0, drop_count 0, out.valid 0, in_ready 1. Reset mid-packet discards all stored and partial data; no flits are emitted after release until new complete packets arrive.
- Input transfer when in.valid && in_ready. in.valid=0 ignored.
- State ACCEPT:
  - in_ready = !full || abort, where abort = full && (rd_ptr == wr_commit), meaning the uncommitted packet occupies the entire buffer.
  - Normal transfer: write at wr_spec, wr_spec++.
  - Transfer with last=1: wr_commit <= wr_spec+1, packet_count++.
  - Transfer while abort: flit discarded, wr_spec <= wr_commit, drop_count++ (saturate). If the flit has last=1, stay in ACCEPT; else go to DROP.
- State DROP:
  - in_ready = 1; all flits discarded.
  - Flit with last=1 returns to ACCEPT; nothing is written.
- Output:
  - out.valid = (rd_ptr != wr_commit). out.data and out.last come combinationally from mem[rd_ptr]. Flit fields are don't-care when valid=0; the bench checks only valid flits.
  - Transfer on out.valid && out_ready: rd_ptr++. A transfer with last=1 decrements packet_count.
- Latency: last flit accepted in cycle N makes out.valid=1 in cycle N+1 (packet previously empty). Throughput is 1 flit/cycle each side.
- Simultaneous events:
  - Read and write in the same cycle are both honoured. The full check uses registered pointers, so a read does not open space in the same cycle.
  - Commit and pop of a last flit in the same cycle leave packet_count unchanged.
  - A packet that is still partial when reads drain the committed data becomes abortable only once full with rd_ptr==wr_commit.
- Out side holds valid and data stable while out_ready=0 (DII handshake rule).
- No packet reordering; packets are never truncated, only dropped whole.

Decomposition:
- dii_flit comes from the shared peripheral_dbg_soc_dii_channel package. No new package types are needed.
- Add the constant DII_PKT_BUF_DEPTH_DEFAULT to that package only if other blocks reuse it.
- One natural sub-module: peripheral_dbg_soc_dii_packet_buffer_mem (simple dual-port register array, write port plus async read port). Pointer, FSM and counter logic stay in the top.

Test Plan:
- Single packet: 3 flits 0xA001/0xA002/0xA003(last), out_ready=1. Expect out.valid low during input, first flit the cycle after last is accepted, three flits in order, packet_count 1->0.
- Back-to-back under backpressure: four 4-flit packets with out_ready=0. Expect in_ready=0 after 16 flits and packet_count=4. Then raise out_ready: 16 flits in order, with in_ready re-asserting the cycle after the first pop.
- Oversize: a 20-flit packet into an empty buffer, DEPTH=16. Expect 16 accepted, the 17th flit discarded with drop_count=1, flits 18-20 discarded in DROP, then ACCEPT. out.valid never asserts; a following 2-flit packet passes intact.
- Oversize packet with last exactly at the abort cycle: flit 17 carries last=1. Expect drop_count=1 and the state stays ACCEPT.
- Streaming: continuous 2-flit packets with both sides valid/ready every cycle. Expect sustained 1 flit/cycle out after the initial latency and no drops.
- Async reset asserted mid-packet with 2 complete packets plus 3 partial flits stored. Expect out.valid=0 immediately, both counters 0, in_ready=1. After release the next packet emerges alone.
